// File: rtl/serial_demux16.sv
// Serial-to-parallel demux: rebuilds a WIDTH-bit word sent LSB-first by a select-stepped mux.
// Optional DEMUX_PARITY_EN adds a trailing even-parity bit check and the parity_err output.
module serial_demux16 #(
  parameter int WIDTH = 16,  // power of two, equals 2**SEL_W
  parameter int SEL_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             din,
  input  logic             din_valid,
  output logic [SEL_W-1:0] s,
  output logic [WIDTH-1:0] w,
  output logic             busy,
  output logic             done
`ifdef DEMUX_PARITY_EN
  ,
  output logic             parity_err
`endif
);

  // Handshake: din is consumed on any rising edge where din_valid=1 while a frame is
  // being collected; there is no back-pressure, and start always takes priority over data.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RECV   = 2'd1
`ifdef DEMUX_PARITY_EN
    ,
    S_PARITY = 2'd2
`endif
  } state_t;

  localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   s_d;
  logic [WIDTH-1:0]   shadow_q, shadow_d;
  logic [WIDTH-1:0]   w_d;
  logic               done_d;
`ifdef DEMUX_PARITY_EN
  logic               perr_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      s        <= '0;
      shadow_q <= '0;
      w        <= '0;
      done     <= 1'b0;
`ifdef DEMUX_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      s        <= s_d;
      shadow_q <= shadow_d;
      w        <= w_d;
      done     <= done_d;
`ifdef DEMUX_PARITY_EN
      parity_err <= perr_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    s_d      = s;
    shadow_d = shadow_q;
    w_d      = w;
    done_d   = 1'b0;
`ifdef DEMUX_PARITY_EN
    perr_d   = parity_err;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_RECV;
          s_d      = '0;
          shadow_d = '0;
        end
      end
      S_RECV: begin
        if (start) begin
          s_d      = '0;
          shadow_d = '0;
        end else if (din_valid) begin
          shadow_d[s] = din;
          s_d         = s + 1'b1;
          if (s == LAST_SLOT) begin
`ifdef DEMUX_PARITY_EN
            state_d = S_PARITY;
`else
            // Publish straight from the incoming bit so w lands on the same edge.
            w_d     = {din, shadow_q[WIDTH-2:0]};
            done_d  = 1'b1;
            state_d = S_IDLE;
`endif
          end
        end
      end
`ifdef DEMUX_PARITY_EN
      S_PARITY: begin
        if (start) begin
          state_d  = S_RECV;
          s_d      = '0;
          shadow_d = '0;
        end else if (din_valid) begin
          w_d     = shadow_q;
          done_d  = 1'b1;
          perr_d  = (^shadow_q) ^ din;
          state_d = S_IDLE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_serial_demux16.sv
// Directed bench for serial_demux16 with a bit-queue reference model checked every cycle.
module tb_serial_demux16;
  localparam int WIDTH = 16;
  localparam int SEL_W = 4;
`ifdef DEMUX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int FRAME_BITS = WIDTH + PB;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic din = 1'b0;
  logic din_valid = 1'b0;
  logic [SEL_W-1:0] s;
  logic [WIDTH-1:0] w;
  logic busy;
  logic done;
`ifdef DEMUX_PARITY_EN
  logic parity_err;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int dut_done_cnt = 0;

  serial_demux16 #(.WIDTH(WIDTH), .SEL_W(SEL_W)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .din(din),
    .din_valid(din_valid),
    .s(s),
    .w(w),
    .busy(busy),
    .done(done)
`ifdef DEMUX_PARITY_EN
    ,
    .parity_err(parity_err)
`endif
  );

  // clock/reset block
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a frame is just the list of valid bits seen since start.
  bit               model_ok = 1'b0;
  bit               m_frame = 1'b0;
  bit               bits[$];
  logic [WIDTH-1:0] m_w = '0;
  bit               m_done = 1'b0;
  bit               m_perr = 1'b0;
  logic [WIDTH-1:0] exp_q[$];

  always @(posedge clk) begin
    model_ok = 1'b1;
    m_done   = 1'b0;
    if (rst) begin
      m_frame = 1'b0;
      bits.delete();
      m_w    = '0;
      m_perr = 1'b0;
      exp_q.delete();
    end else if (!m_frame) begin
      if (start) begin
        m_frame = 1'b1;
        bits.delete();
      end
    end else if (start) begin
      bits.delete();
    end else if (din_valid) begin
      bits.push_back(din);
      if (bits.size() == FRAME_BITS) begin
        m_perr = 1'b0;
        for (int i = 0; i < FRAME_BITS; i++) m_perr = m_perr ^ bits[i];
        for (int i = 0; i < WIDTH; i++) m_w[i] = bits[i];
        exp_q.push_back(m_w);
        m_done  = 1'b1;
        m_frame = 1'b0;
        bits.delete();
      end
    end
  end

  // Scoreboard: every output compared on the falling edge.
  always @(negedge clk) begin
    if (model_ok) begin
      check("s", 32'(s), m_frame ? 32'(bits.size() % WIDTH) : 32'd0);
      check("busy", 32'(busy), 32'(m_frame));
      check("done", 32'(done), 32'(m_done));
      check("w", 32'(w), 32'(m_w));
`ifdef DEMUX_PARITY_EN
      check("parity_err", 32'(parity_err), 32'(m_perr));
`endif
      if (done === 1'b1) begin
        dut_done_cnt++;
        if (exp_q.size() == 0) check("unexpected_done", 32'd1, 32'd0);
        else check("published_word", 32'(w), 32'(exp_q.pop_front()));
      end
    end
  end

  // driver tasks: inputs change 1 time unit after the rising edge
  task automatic drive(input logic st, input logic v, input logic d);
    start = st;
    din_valid = v;
    din = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_bits(input logic [WIDTH-1:0] data, input int first, input int n);
    for (int i = first; i < first + n; i++) drive(1'b0, 1'b1, data[i]);
  endtask

  task automatic finish_frame(input logic [WIDTH-1:0] data);
    if (PB != 0) drive(1'b0, 1'b1, ^data);
  endtask

  task automatic full_frame(input logic [WIDTH-1:0] data);
    drive(1'b1, 1'b0, 1'b0);
    send_bits(data, 0, WIDTH);
    finish_frame(data);
  endtask

  int done_before;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_s", 32'(s), 32'd0);
    check("rst_w", 32'(w), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst = 1'b0;

    // din ignored while idle
    drive(1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 1'b1);
    check("idle_s", 32'(s), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);

    // single frame 0x0001
    drive(1'b1, 1'b0, 1'b0);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_s0", 32'(s), 32'd0);
    send_bits(16'h0001, 0, 15);
    check("t1_s15", 32'(s), 32'd15);
    check("t1_nodone", 32'(done), 32'd0);
    send_bits(16'h0001, 15, 1);
    finish_frame(16'h0001);
    check("t1_done", 32'(done), 32'd1);
    check("t1_w", 32'(w), 32'h0001);
    check("t1_s", 32'(s), 32'd0);
    check("t1_idle", 32'(busy), 32'd0);
    idle(1);
    check("t1_pulse", 32'(done), 32'd0);
    idle(2);

    // 0x8000 with a 3-cycle gap after bit 7
    drive(1'b1, 1'b0, 1'b0);
    send_bits(16'h8000, 0, 8);
    for (int i = 0; i < 3; i++) begin
      check("t2_gap_s", 32'(s), 32'd8);
      drive(1'b0, 1'b0, 1'b1);
    end
    check("t2_gap_end_s", 32'(s), 32'd8);
    send_bits(16'h8000, 8, 7);
    check("t2_w_held", 32'(w), 32'h0001);
    send_bits(16'h8000, 15, 1);
    finish_frame(16'h8000);
    check("t2_done", 32'(done), 32'd1);
    check("t2_w", 32'(w), 32'h8000);

    // back-to-back frames, start in the done cycle
    idle(1);
    full_frame(16'h0004);
    check("t3_done_a", 32'(done), 32'd1);
    check("t3_w_a", 32'(w), 32'h0004);
    drive(1'b1, 1'b0, 1'b0);
    check("t3_restart_busy", 32'(busy), 32'd1);
    send_bits(16'h2000, 0, WIDTH);
    finish_frame(16'h2000);
    check("t3_done_b", 32'(done), 32'd1);
    check("t3_w_b", 32'(w), 32'h2000);

    // abort mid-frame with start (valid bit in the same cycle ignored)
    idle(1);
    done_before = dut_done_cnt;
    drive(1'b1, 1'b0, 1'b0);
    send_bits(16'hFFFF, 0, 9);
    check("t4_s9", 32'(s), 32'd9);
    drive(1'b1, 1'b1, 1'b1);
    check("t4_restart_s", 32'(s), 32'd0);
    check("t4_restart_busy", 32'(busy), 32'd1);
    send_bits(16'h00F0, 0, 15);
    check("t4_w_held", 32'(w), 32'h2000);
    send_bits(16'h00F0, 15, 1);
    finish_frame(16'h00F0);
    check("t4_w", 32'(w), 32'h00F0);
    idle(2);
    check("t4_one_done", 32'(dut_done_cnt - done_before), 32'd1);

    // reset mid-frame
    drive(1'b1, 1'b0, 1'b0);
    send_bits(16'hFFFF, 0, 10);
    check("t5_s10", 32'(s), 32'd10);
    rst = 1'b1;
    drive(1'b0, 1'b1, 1'b1);
    rst = 1'b0;
    check("t5_s", 32'(s), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_w", 32'(w), 32'd0);
    check("t5_done", 32'(done), 32'd0);
    idle(2);
    full_frame(16'hA5A5);
    check("t5_frame_done", 32'(done), 32'd1);
    check("t5_frame_w", 32'(w), 32'hA5A5);
    idle(1);

`ifdef DEMUX_PARITY_EN
    drive(1'b1, 1'b0, 1'b0);
    send_bits(16'h0003, 0, WIDTH);
    check("p1_wait_busy", 32'(busy), 32'd1);
    check("p1_wait_s", 32'(s), 32'd0);
    check("p1_wait_done", 32'(done), 32'd0);
    drive(1'b0, 1'b1, 1'b0);
    check("p1_done", 32'(done), 32'd1);
    check("p1_perr", 32'(parity_err), 32'd0);
    check("p1_w", 32'(w), 32'h0003);
    drive(1'b1, 1'b0, 1'b0);
    send_bits(16'h0001, 0, WIDTH);
    drive(1'b0, 1'b1, 1'b0);
    check("p2_done", 32'(done), 32'd1);
    check("p2_perr", 32'(parity_err), 32'd1);
    check("p2_w", 32'(w), 32'h0001);
    idle(3);
    check("p2_perr_held", 32'(parity_err), 32'd1);
`endif

    idle(2);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
